// File: rtl/rx_lane_deskew_pkg.sv
// Shared state encodings, ordered-set marker symbols and
// marker detection for the RX lane deskew stage.
package rx_lane_deskew_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ALIGNED = 2'd1,
        ST_FLUSH   = 2'd2
    } dsk_state_e;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] SKP_G3 = 8'hAA;
    localparam logic [7:0] TS1_G3 = 8'h1E;
    localparam logic [7:0] TS2_G3 = 8'h2D;
    localparam logic [1:0] SH_OS  = 2'b01;

    // Marker is judged on the lowest byte of a lane word only.
    function automatic logic is_marker(
        input logic [2:0] gen,
        input logic       k0,
        input logic [7:0] b0,
        input logic [1:0] sh
    );
        if (gen < 3'd3) begin
            return k0 && (b0 == COM);
        end
        return (sh == SH_OS) &&
               ((b0 == SKP_G3) || (b0 == TS1_G3) || (b0 == TS2_G3));
    endfunction

endpackage

// File: rtl/deskew_lane_fifo.sv
// Per-lane elastic FIFO holding {syncheader, K flags, data}.
// Extra pointer MSB distinguishes full from empty.
module deskew_lane_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [DATA_W+DATA_W/8+1:0]   i_wdata,
    output logic [DATA_W+DATA_W/8+1:0]   o_rdata,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = DATA_W + DATA_W / 8 + 2;

    logic [FW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A pop on an empty FIFO never happens, even alongside a push.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/rx_lane_deskew.sv
// Multi-lane deskew: per-lane elastic FIFOs aligned on ordered-set
// markers, then released in lock-step to the LMC.
module rx_lane_deskew
    import rx_lane_deskew_pkg::*;
#(
    parameter int LANES    = 16,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int MAX_SKEW = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2:0]                GEN,
    input  logic [4:0]                numberOfDetectedLanes,
    input  logic                      deskew_en,
    input  logic [LANES-1:0]          in_valid,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES*DATA_W/8-1:0] in_datak,
    input  logic [2*LANES-1:0]        in_syncheader,
    output logic                      out_valid,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [LANES*DATA_W/8-1:0] out_datak,
    output logic [2*LANES-1:0]        out_syncheader,
    output logic                      aligned,
    output logic                      deskew_error,
    output logic [7:0]                realign_count,
    output logic [3:0]                max_skew_seen
);

    localparam int KW = DATA_W / 8;
    localparam int FW = DATA_W + KW + 2;
    localparam logic [7:0] SKEW_LIM = 8'(MAX_SKEW);

    dsk_state_e r_state;
    dsk_state_e w_state_nxt;

    logic [2:0]              r_gen_q;
    logic [4:0]              r_n_q;
    logic [7:0]              r_skew_cnt;
    logic [3:0]              r_max_skew;
    logic [7:0]              r_realign;
    logic                    r_err;
    logic                    r_out_valid;
    logic [LANES*DATA_W-1:0] r_out_data;
    logic [LANES*KW-1:0]     r_out_datak;
    logic [2*LANES-1:0]      r_out_sh;

    logic                    w_n_ok;
    logic                    w_cfg_chg;
    logic                    w_flush;
    logic [LANES-1:0]        w_active;
    logic [LANES-1:0]        w_push;
    logic [LANES-1:0]        w_pop;
    logic [LANES-1:0]        w_full;
    logic [LANES-1:0]        w_empty;
    logic [LANES-1:0]        w_mark;
    logic [LANES-1:0]        w_hold;
    logic [LANES-1:0]        w_pmk;
    logic [FW-1:0]           w_wdata [LANES];
    logic [FW-1:0]           w_head  [LANES];
    logic [LANES*DATA_W-1:0] w_fd;
    logic [LANES*KW-1:0]     w_fk;
    logic [2*LANES-1:0]      w_fs;
    logic [LANES*DATA_W-1:0] w_bd;
    logic [LANES*KW-1:0]     w_bk;
    logic [2*LANES-1:0]      w_bs;
    logic                    w_byp_valid;
    logic                    w_any_full;
    logic                    w_any_empty;
    logic                    w_any_mk;
    logic                    w_all_mk;
    logic                    w_loss;
    logic [3:0]              w_meas;
    logic [7:0]              w_cnt_nxt;
    logic [3:0]              w_max_nxt;
    logic [7:0]              w_rc_nxt;
    logic                    w_err;
    logic                    w_out_ld;

    assign w_n_ok = (numberOfDetectedLanes != 5'd0) &&
                    (int'(numberOfDetectedLanes) <= LANES);
    assign w_cfg_chg = (GEN != r_gen_q) ||
                       (numberOfDetectedLanes != r_n_q);
    assign w_flush = !deskew_en || !w_n_ok || (r_state == ST_FLUSH);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_active[i] = w_n_ok &&
                             (int'(numberOfDetectedLanes) > i);
        assign w_push[i] = in_valid[i] && w_active[i] && !w_flush;
        assign w_wdata[i] = {in_syncheader[2*i +: 2],
                             in_datak[i*KW +: KW],
                             in_data[i*DATA_W +: DATA_W]};

        deskew_lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[i]),
            .i_pop   (w_pop[i]),
            .i_flush (w_flush),
            .i_wdata (w_wdata[i]),
            .o_rdata (w_head[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );

        assign w_mark[i] = is_marker(GEN, w_head[i][DATA_W],
                                     w_head[i][7:0],
                                     w_head[i][FW-1 -: 2]);

        assign w_fd[i*DATA_W +: DATA_W] =
            w_active[i] ? w_head[i][DATA_W-1:0] : '0;
        assign w_fk[i*KW +: KW] =
            w_active[i] ? w_head[i][DATA_W +: KW] : '0;
        assign w_fs[2*i +: 2] =
            w_active[i] ? w_head[i][FW-1 -: 2] : '0;

        assign w_bd[i*DATA_W +: DATA_W] =
            w_active[i] ? in_data[i*DATA_W +: DATA_W] : '0;
        assign w_bk[i*KW +: KW] =
            w_active[i] ? in_datak[i*KW +: KW] : '0;
        assign w_bs[2*i +: 2] =
            w_active[i] ? in_syncheader[2*i +: 2] : '0;
    end

    assign w_byp_valid = w_n_ok && (&(in_valid | ~w_active));

    assign w_hold      = w_active & ~w_empty & w_mark;
    assign w_any_mk    = |w_hold;
    assign w_all_mk    = (w_hold == w_active);
    assign w_any_full  = |(w_active & w_full);
    assign w_any_empty = |(w_active & w_empty);
    assign w_pmk       = w_active & w_mark;

    // Loss: heads disagree on marker position, or one lane is
    // starving while another overflows.
    assign w_loss = (!w_any_empty && (|w_pmk) && (w_pmk != w_active)) ||
                    (w_any_full && w_any_empty);

    assign w_meas = (r_skew_cnt > 8'd15) ? 4'hF : r_skew_cnt[3:0];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = '0;
        w_cnt_nxt   = '0;
        w_max_nxt   = r_max_skew;
        w_rc_nxt    = r_realign;
        w_err       = 1'b0;
        w_out_ld    = 1'b0;
        if (!deskew_en || !w_n_ok) begin
            w_state_nxt = ST_SEARCH;
        end else if (w_cfg_chg) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    w_pop = w_active & ~w_empty & ~w_mark;
                    if ((r_skew_cnt > SKEW_LIM) || w_any_full) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else if (w_all_mk) begin
                        w_state_nxt = ST_ALIGNED;
                        if (w_meas > r_max_skew) w_max_nxt = w_meas;
                    end else if (w_any_mk) begin
                        w_cnt_nxt = (r_skew_cnt == 8'hFF) ?
                                    r_skew_cnt : r_skew_cnt + 8'd1;
                    end
                end
                ST_ALIGNED: begin
                    if (w_loss) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_FLUSH;
                        w_rc_nxt    = (r_realign == 8'hFF) ?
                                      r_realign : r_realign + 8'd1;
                    end else if (!w_any_empty) begin
                        w_pop    = w_active;
                        w_out_ld = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    w_state_nxt = ST_SEARCH;
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_gen_q     <= GEN;
            r_n_q       <= numberOfDetectedLanes;
            r_skew_cnt  <= '0;
            r_max_skew  <= '0;
            r_realign   <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_datak <= '0;
            r_out_sh    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gen_q    <= GEN;
            r_n_q      <= numberOfDetectedLanes;
            r_skew_cnt <= w_cnt_nxt;
            r_max_skew <= w_max_nxt;
            r_realign  <= w_rc_nxt;
            r_err      <= w_err;
            if (!deskew_en) begin
                r_out_valid <= w_byp_valid;
                r_out_data  <= w_bd;
                r_out_datak <= w_bk;
                r_out_sh    <= w_bs;
            end else if (w_out_ld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_fd;
                r_out_datak <= w_fk;
                r_out_sh    <= w_fs;
            end else begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_out_datak <= '0;
                r_out_sh    <= '0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_datak      = r_out_datak;
    assign out_syncheader = r_out_sh;
    assign aligned        = deskew_en && (r_state == ST_ALIGNED);
    assign deskew_error   = r_err;
    assign realign_count  = r_realign;
    assign max_skew_seen  = r_max_skew;

endmodule

// File: tb/tb_rx_lane_deskew.sv
// Directed bench for rx_lane_deskew: skew measurement, overflow,
// alignment loss, lane-count change, bypass and reset.
module tb_rx_lane_deskew;

    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int KW    = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [2:0]            GEN;
    logic [4:0]            numberOfDetectedLanes;
    logic                  deskew_en;
    logic [LANES-1:0]      in_valid;
    logic [LANES*DW-1:0]   in_data;
    logic [LANES*KW-1:0]   in_datak;
    logic [2*LANES-1:0]    in_syncheader;
    logic                  out_valid;
    logic [LANES*DW-1:0]   out_data;
    logic [LANES*KW-1:0]   out_datak;
    logic [2*LANES-1:0]    out_syncheader;
    logic                  aligned;
    logic                  deskew_error;
    logic [7:0]            realign_count;
    logic [3:0]            max_skew_seen;

    int n_chk  = 0;
    int n_fail = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    rx_lane_deskew #(
        .LANES    (LANES),
        .DATA_W   (DW),
        .DEPTH    (8),
        .MAX_SKEW (6)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .GEN                   (GEN),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .deskew_en             (deskew_en),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_datak              (in_datak),
        .in_syncheader         (in_syncheader),
        .out_valid             (out_valid),
        .out_data              (out_data),
        .out_datak             (out_datak),
        .out_syncheader        (out_syncheader),
        .aligned               (aligned),
        .deskew_error          (deskew_error),
        .realign_count         (realign_count),
        .max_skew_seen         (max_skew_seen)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (deskew_error) n_err++;
    endtask

    task automatic idle_all();
        in_valid      = '0;
        in_data       = '0;
        in_datak      = '0;
        in_syncheader = '0;
    endtask

    task automatic set_lane(input int l, input logic v,
                            input logic [31:0] d, input logic [3:0] k,
                            input logic [1:0] sh);
        in_valid[l]            = v;
        in_data[l*DW +: DW]    = d;
        in_datak[l*KW +: KW]   = k;
        in_syncheader[2*l +: 2] = sh;
    endtask

    task automatic send_word(input int l, input bit mk, input bit g3);
        if (mk && !g3) set_lane(l, 1'b1, 32'h0000_00BC, 4'h1, 2'b00);
        else if (mk)   set_lane(l, 1'b1, 32'h0000_00AA, 4'h0, 2'b01);
        else if (!g3)  set_lane(l, 1'b1, 32'h2525_2525, 4'h0, 2'b00);
        else           set_lane(l, 1'b1, 32'h2525_2525, 4'h0, 2'b10);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        GEN = 3'd1;
        numberOfDetectedLanes = 5'd2;
        deskew_en = 1'b1;
        idle_all();
        tick();
        tick();
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_datak !== '0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b got nonzero data", out_valid);
        end
        n_chk++;
        if (aligned !== 1'b0 || deskew_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: aligned=%b err=%b want 0 0",
                     aligned, deskew_error);
        end
        n_chk++;
        if (realign_count !== 8'd0 || max_skew_seen !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: rc=%0d max=%0d want 0 0",
                     realign_count, max_skew_seen);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_skew_measure();
        int first_v;
        int nv;
        int bad;
        int idx;
        logic [31:0] ed;
        logic [3:0]  ek;
        first_v = -1;
        nv = 0;
        bad = 0;
        n_err = 0;
        for (int c = 0; c < 16; c++) begin
            idle_all();
            for (int l = 0; l < 2; l++) begin
                idx = c - ((l == 0) ? 0 : 3);
                if (idx >= 0 && idx < 9) send_word(l, idx == 0, 1'b0);
            end
            tick();
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                ed = (nv == 0) ? 32'h0000_00BC : 32'h2525_2525;
                ek = (nv == 0) ? 4'h1 : 4'h0;
                if (out_data[31:0] !== ed || out_data[63:32] !== ed ||
                    out_datak[3:0] !== ek || out_datak[7:4] !== ek ||
                    out_data[LANES*DW-1:64] !== '0)
                    bad++;
                nv++;
            end
        end
        idle_all();
        n_chk++;
        if (first_v !== 5) begin
            n_fail++;
            $display("FAIL skew_latency: first valid cycle %0d want 5", first_v);
        end
        n_chk++;
        if (nv !== 9) begin
            n_fail++;
            $display("FAIL skew_count: %0d words out want 9", nv);
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL skew_data: %0d bad words want 0", bad);
        end
        n_chk++;
        if (max_skew_seen !== 4'd3) begin
            n_fail++;
            $display("FAIL skew_max: got %0d want 3", max_skew_seen);
        end
        n_chk++;
        if (n_err !== 0 || aligned !== 1'b1) begin
            n_fail++;
            $display("FAIL skew_state: errs=%0d aligned=%b want 0 1",
                     n_err, aligned);
        end
    endtask

    task automatic test_skew_overflow();
        int err_c;
        int nv;
        int idx;
        GEN = 3'd3;
        numberOfDetectedLanes = 5'd4;
        idle_all();
        tick();
        tick();
        tick();
        n_err = 0;
        err_c = -1;
        nv = 0;
        for (int c = 0; c < 18; c++) begin
            idle_all();
            for (int l = 0; l < 4; l++) begin
                idx = c - ((l == 2) ? 7 : 0);
                if (idx >= 0 && idx < 9) send_word(l, idx == 0, 1'b1);
            end
            tick();
            if (deskew_error && err_c < 0) err_c = c;
            if (out_valid) nv++;
        end
        idle_all();
        n_chk++;
        if (n_err !== 1 || err_c !== 8) begin
            n_fail++;
            $display("FAIL ovf_error: pulses=%0d at %0d want 1 at 8",
                     n_err, err_c);
        end
        n_chk++;
        if (nv !== 0 || aligned !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_state: outs=%0d aligned=%b want 0 0",
                     nv, aligned);
        end
        tick();
        tick();
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            idle_all();
            if (c < 5)
                for (int l = 0; l < 4; l++) send_word(l, c == 0, 1'b1);
            tick();
            if (out_valid && out_data[95:64] === out_data[31:0] &&
                out_syncheader[5:4] === out_syncheader[1:0])
                nv++;
        end
        idle_all();
        n_chk++;
        if (aligned !== 1'b1 || realign_count !== 8'd0) begin
            n_fail++;
            $display("FAIL ovf_realign: aligned=%b rc=%0d want 1 0",
                     aligned, realign_count);
        end
        n_chk++;
        if (nv !== 5 || max_skew_seen !== 4'd3) begin
            n_fail++;
            $display("FAIL ovf_outs: outs=%0d max=%0d want 5 3",
                     nv, max_skew_seen);
        end
    endtask

    task automatic test_word_drop();
        int err_c;
        logic al8;
        numberOfDetectedLanes = 5'd2;
        idle_all();
        tick();
        tick();
        tick();
        n_err = 0;
        err_c = -1;
        al8 = 1'bx;
        for (int c = 0; c < 10; c++) begin
            idle_all();
            send_word(1, c == 0 || c == 7, 1'b1);
            if (c != 5) send_word(0, c == 0 || c == 7, 1'b1);
            tick();
            if (deskew_error && err_c < 0) err_c = c;
            if (c == 8) al8 = aligned;
        end
        idle_all();
        n_chk++;
        if (n_err !== 1 || err_c !== 8) begin
            n_fail++;
            $display("FAIL drop_error: pulses=%0d at %0d want 1 at 8",
                     n_err, err_c);
        end
        n_chk++;
        if (realign_count !== 8'd1 || al8 !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_loss: rc=%0d aligned=%b want 1 0",
                     realign_count, al8);
        end
        tick();
        send_word(0, 1'b1, 1'b1);
        send_word(1, 1'b1, 1'b1);
        tick();
        idle_all();
        tick();
        n_chk++;
        if (aligned !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_realign: aligned=%b want 1", aligned);
        end
    endtask

    task automatic test_lane_change();
        int nv;
        n_err = 0;
        nv = 0;
        numberOfDetectedLanes = 5'd4;
        tick();
        n_chk++;
        if (aligned !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_aligned: aligned=%b want 0", aligned);
        end
        tick();
        if (out_valid) nv++;
        tick();
        if (out_valid) nv++;
        n_chk++;
        if (n_err !== 0 || realign_count !== 8'd1 || nv !== 0) begin
            n_fail++;
            $display("FAIL chg_quiet: errs=%0d rc=%0d outs=%0d want 0 1 0",
                     n_err, realign_count, nv);
        end
        for (int l = 0; l < 4; l++) send_word(l, 1'b1, 1'b1);
        tick();
        idle_all();
        tick();
        n_chk++;
        if (aligned !== 1'b1) begin
            n_fail++;
            $display("FAIL chg_search: aligned=%b want 1", aligned);
        end
    endtask

    task automatic test_bypass();
        deskew_en = 1'b0;
        numberOfDetectedLanes = 5'd2;
        idle_all();
        set_lane(0, 1'b1, 32'hAABB_CCDD, 4'h5, 2'b10);
        set_lane(1, 1'b1, 32'h1122_3344, 4'h0, 2'b01);
        set_lane(2, 1'b1, 32'h5566_7788, 4'hF, 2'b11);
        tick();
        n_chk++;
        if (out_data[31:0] !== 32'hAABB_CCDD ||
            out_data[63:32] !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL byp_data: got %h %h want aabbccdd 11223344",
                     out_data[31:0], out_data[63:32]);
        end
        n_chk++;
        if (out_data[LANES*DW-1:64] !== '0 ||
            out_datak[LANES*KW-1:8] !== '0 ||
            out_syncheader[2*LANES-1:4] !== '0) begin
            n_fail++;
            $display("FAIL byp_inactive: lanes 2..15 not zero");
        end
        n_chk++;
        if (out_datak[3:0] !== 4'h5 || out_syncheader[3:0] !== 4'b0110) begin
            n_fail++;
            $display("FAIL byp_k_sh: k=%h sh=%b want 5 0110",
                     out_datak[3:0], out_syncheader[3:0]);
        end
        n_chk++;
        if (out_valid !== 1'b1 || aligned !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_flags: valid=%b aligned=%b want 1 0",
                     out_valid, aligned);
        end
        in_valid[1] = 1'b0;
        tick();
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_and: valid=%b want 0", out_valid);
        end
        idle_all();
    endtask

    task automatic test_reset_mid();
        int nv;
        deskew_en = 1'b1;
        idle_all();
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            for (int l = 0; l < 2; l++) send_word(l, c == 0, 1'b1);
            tick();
        end
        n_chk++;
        if (aligned !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstm_pre: aligned=%b valid=%b want 1 1",
                     aligned, out_valid);
        end
        reset = 1'b1;
        tick();
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== '0 || aligned !== 1'b0 ||
            deskew_error !== 1'b0 || realign_count !== 8'd0 ||
            max_skew_seen !== 4'd0) begin
            n_fail++;
            $display("FAIL rstm_out: valid=%b aligned=%b rc=%0d max=%0d",
                     out_valid, aligned, realign_count, max_skew_seen);
        end
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 2; l++) send_word(l, 1'b0, 1'b1);
            tick();
            if (out_valid || aligned) nv++;
        end
        n_chk++;
        if (nv !== 0) begin
            n_fail++;
            $display("FAIL rstm_empty: %0d active cycles want 0", nv);
        end
        for (int l = 0; l < 2; l++) send_word(l, 1'b1, 1'b1);
        tick();
        idle_all();
        tick();
        n_chk++;
        if (aligned !== 1'b1) begin
            n_fail++;
            $display("FAIL rstm_search: aligned=%b want 1", aligned);
        end
    endtask

    initial begin
        test_reset();
        test_skew_measure();
        test_skew_overflow();
        test_word_drop();
        test_lane_change();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_lane_deskew.md
Name: rx_lane_deskew

Overview:
Parametrised multi-lane deskew and alignment stage, placed between the per-lane Descrambler outputs and the LMC in the RX path. Each lane has an elastic FIFO. The block uses per-lane ordered-set markers to equalise inter-lane skew at word granularity, then releases all active lanes in lock-step. It adds alignment tracking, skew measurement and a realignment state machine that the current RX path does not have.

Parameters:
LANES, 16, number of physical lanes (1..16)
DATA_W, 32, bits per lane per cycle (multiple of 8)
DEPTH, 8, words per lane FIFO (power of 2, >=4)
MAX_SKEW, 6, maximum tolerated skew in words (must be < DEPTH)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
GEN  in  3  current generation (1..5)
numberOfDetectedLanes  in  5  active lanes, lanes 0..N-1
deskew_en  in  1  0 = bypass (registered pass-through)
in_valid  in  LANES  per-lane word valid
in_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
in_datak  in  LANES*DATA_W/8  K flags, one per byte
in_syncheader  in  2*LANES  Gen3+ sync header per lane
out_valid  out  1  all active lanes valid together
out_data  out  LANES*DATA_W  deskewed data; inactive lanes = 0
out_datak  out  LANES*DATA_W/8  deskewed K flags
out_syncheader  out  2*LANES  deskewed sync headers
aligned  out  1  high in ALIGNED state
deskew_error  out  1  one-cycle pulse on skew overflow or alignment loss
realign_count  out  8  saturating count of realignments
max_skew_seen  out  4  largest measured skew (words), saturating at 15

Behaviour:
- Reset: all outputs 0, all FIFOs empty, state SEARCH.
- Marker, judged on the first (lowest) byte of a word:
  - GEN<3: K=1 and byte=8'hBC (COM).
  - GEN>=3: sync header=2'b01 and byte in {8'hAA, 8'h1E, 8'h2D}.
- FIFO write: a lane's FIFO is written whenever its in_valid=1, in every state except FLUSH.
- N = numberOfDetectedLanes. If N=0 or N>LANES: state held in SEARCH, no output, FIFOs flushed every cycle.
- States:
  - SEARCH:
    - Any active lane whose FIFO head is a non-marker word is popped and discarded.
    - Lanes with a marker at the head hold.
    - A skew counter starts on the first cycle any active lane holds a marker and increments each cycle until all active lanes hold one.
    - All active lanes hold a marker → ALIGNED; max_skew_seen = max(current, counter).
    - Counter > MAX_SKEW, or any active FIFO full → deskew_error pulse, go to FLUSH.
  - ALIGNED:
    - When every active FIFO is non-empty, all heads pop in the same cycle.
    - Output is registered; out_valid=1 the following cycle.
    - Minimum in→out latency is 2 cycles.
  - Alignment loss (in ALIGNED): the popped heads show a marker on some but not all active lanes, or any active FIFO is full while another is empty. Response: deskew_error pulse, realign_count+1 (saturating at 255), go to FLUSH.
  - FLUSH: one cycle; all FIFOs emptied, in_valid ignored; then SEARCH.
- GEN or numberOfDetectedLanes change: on the cycle the change is seen, go to FLUSH from any state; aligned drops the next cycle. No error pulse, no count.
- deskew_en=0: FIFOs and FSM held in reset; out_* = in_* registered (1 cycle); out_valid = AND of in_valid over active lanes; aligned=0.
- deskew_en 0→1: enter SEARCH with empty FIFOs.
- Inactive lanes: writes suppressed; outputs forced to 0.
- FIFO pointers: log2(DEPTH)+1 bits, wrap naturally. Full is asserted when the MSBs differ and the rest are equal. A simultaneous push and pop on a full FIFO is allowed; on an empty FIFO a push and a pop in the same cycle does not pop.

Decomposition:
- Shared include rx_deskew_defs: state encodings (SEARCH=0, ALIGNED=1, FLUSH=2), COM=8'hBC, SKP_G3=8'hAA, TS1_G3=8'h1E, TS2_G3=8'h2D, SH_OS=2'b01.
- One sub-module, deskew_lane_fifo (DATA_W, DEPTH): synchronous FIFO, width DATA_W+DATA_W/8+2, with push, pop, flush, head word, full and empty. Instantiated LANES times in a generate loop.
- FSM, marker detection and the skew counter live in the top.

Test Plan:
- GEN=1, N=2, lane1 delayed 3 words; each lane sends BC(K) marker, then 8 words 0x25252525 → aligned=1; markers exit together; max_skew_seen=3; no deskew_error.
- GEN=3, N=4, lane2 delayed 7 words, MAX_SKEW=6 → deskew_error pulses once, FLUSH, SEARCH; after the delay is cleared and markers are resent → aligned=1, realign_count=0.
- While ALIGNED with N=2, drop one word on lane0 only → next marker mismatch; deskew_error pulse, realign_count=1, aligned=0, realign on the next marker pair.
- numberOfDetectedLanes changes 2→4 while ALIGNED → aligned=0 on the next cycle, no error pulse, FIFOs empty; SEARCH resumes.
- deskew_en=0, N=2, in_data lane0=0xAABBCCDD → out_data lane0=0xAABBCCDD one cycle later; lanes 2..15 = 0; aligned=0.
- Assert reset mid-ALIGNED with full FIFOs → the next cycle all outputs are 0, FIFOs are empty and the state is SEARCH.
